// File: rtl/ocupacao_ctrl.sv
// Occupancy state controller for the room indicator (feeds led_rgb.ocupado).
// Raw presence is synchronised and debounced, then drives a three-state
// occupancy FSM with a release hold-off, a blinking warning while the room
// is vacating and a manual force-free command.
module ocupacao_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 100,
  parameter int BLINK_HALF      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       presenca,
  input  logic       forcar_livre,
  output logic       ocupado,
  output logic       aviso,
  output logic [1:0] estado,
  output logic       evento_entrada
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // The state register is the estado output, so checkers can bind to it.
  typedef enum logic [1:0] {
    LIVRE      = 2'b00,
    OCUPADO    = 2'b01,
    AGUARDANDO = 2'b10,
    ILEGAL     = 2'b11
  } state_t;

  logic          s1, s2;
  logic          pres_f;
  logic [DW-1:0] deb_cnt;
  logic          inibe;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [BW-1:0] blink_cnt, blink_n;
  logic          fase, fase_n;
  logic          entra;

  // Two-flop synchroniser for the asynchronous sensor input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= presenca;
      s2 <= s1;
    end
  end

  // Debounce: pres_f follows s2 only after it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_f  <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 != pres_f) begin
      if (deb_cnt == DEB_LAST) begin
        pres_f  <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Inhibit after a forced release until presence is seen low again,
  // so the room cannot be re-occupied by the same lingering presence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inibe <= 1'b0;
    end else if (forcar_livre) begin
      inibe <= 1'b1;
    end else if (!pres_f) begin
      inibe <= 1'b0;
    end
  end

  // Next-state, hold countdown and blink phase; forcar_livre overrides everything.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    entra   = 1'b0;
    blink_n = blink_cnt;
    fase_n  = fase;

    case (state)
      LIVRE: begin
        if (pres_f && !inibe) begin
          state_n = OCUPADO;
          entra   = 1'b1;
        end
      end
      OCUPADO: begin
        if (!pres_f) begin
          state_n = AGUARDANDO;
          hold_n  = HOLD_LAST;
        end
      end
      AGUARDANDO: begin
        if (pres_f) begin
          state_n = OCUPADO;
        end else if (hold_cnt == '0) begin
          state_n = LIVRE;
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
      default: state_n = LIVRE;
    endcase

    if (forcar_livre) begin
      state_n = LIVRE;
      hold_n  = '0;
      entra   = 1'b0;
    end

    // Blink restarts with aviso high on every entry into AGUARDANDO.
    if (state_n == AGUARDANDO && state != AGUARDANDO) begin
      blink_n = '0;
      fase_n  = 1'b1;
    end else if (state == AGUARDANDO && state_n == AGUARDANDO) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_n = '0;
        fase_n  = ~fase;
      end else begin
        blink_n = blink_cnt + 1'b1;
      end
    end
  end

  // State, counters and the registered entry pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LIVRE;
      hold_cnt       <= '0;
      blink_cnt      <= '0;
      fase           <= 1'b0;
      evento_entrada <= 1'b0;
    end else begin
      state          <= state_n;
      hold_cnt       <= hold_n;
      blink_cnt      <= blink_n;
      fase           <= fase_n;
      evento_entrada <= entra;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    ocupado = (state == OCUPADO) || (state == AGUARDANDO);
    aviso   = (state == AGUARDANDO) && fase;
    estado  = state;
  end

endmodule

// File: tb/tb_ocupacao_ctrl.sv
// Self-checking bench for ocupacao_ctrl: directed scenarios plus random
// sensor activity, compared against a behavioural occupancy model.
module tb_ocupacao_ctrl;

  localparam int D = 4;
  localparam int H = 20;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       presenca;
  logic       forcar_livre;
  logic       ocupado;
  logic       aviso;
  logic [1:0] estado;
  logic       evento_entrada;

  logic [4:0] dut_vec;
  assign dut_vec = {estado, ocupado, aviso, evento_entrada};

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  logic [4:0] e;

  ocupacao_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .BLINK_HALF(B)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .presenca(presenca),
    .forcar_livre(forcar_livre),
    .ocupado(ocupado),
    .aviso(aviso),
    .estado(estado),
    .evento_entrada(evento_entrada)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // sensor pipeline: value seen one and two edges ago
  bit m_s1, m_s2;
  // filtered presence and how many consecutive edges the pipeline disagreed with it
  bit m_pf;
  int m_run;
  // occupied flag, cycles spent vacating (-1 = not vacating), re-entry inhibit, entry pulse
  bit m_occ;
  int m_wait;
  bit m_inh;
  bit m_evt;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_pf = 0; m_run = 0;
    m_occ = 0; m_wait = -1; m_inh = 0; m_evt = 0;
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] st;
    logic       av;
    if (!m_occ) st = 2'b00;
    else if (m_wait < 0) st = 2'b01;
    else st = 2'b10;
    av = (m_wait >= 0) && (((m_wait / B) % 2) == 0);
    return {st, m_occ, av, m_evt};
  endfunction

  task automatic model_edge();
    bit npf;
    int nrun;
    npf  = m_pf;
    nrun = 0;
    if (m_s2 != m_pf) begin
      if (m_run + 1 >= D) npf = m_s2;
      else nrun = m_run + 1;
    end
    m_evt = 0;
    if (forcar_livre) begin
      m_occ  = 0;
      m_wait = -1;
    end else if (!m_occ) begin
      if (m_pf && !m_inh) begin
        m_occ = 1;
        m_evt = 1;
      end
    end else if (m_wait < 0) begin
      if (!m_pf) m_wait = 0;
    end else begin
      if (m_pf) m_wait = -1;
      else if (m_wait == H - 1) begin
        m_occ  = 0;
        m_wait = -1;
      end else m_wait++;
    end
    if (forcar_livre) m_inh = 1;
    else if (!m_pf) m_inh = 0;
    m_s2  = m_s1;
    m_s1  = presenca;
    m_pf  = npf;
    m_run = nrun;
  endtask

  // driver: one clock edge, model advanced, expectation queued
  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; presenca = 1'b1; forcar_livre = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 5'b0) begin
      errors++; $display("FAIL reset_async: got %b exp %b", dut_vec, 5'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 5'b0) begin
      errors++; $display("FAIL reset_held: got %b exp %b", dut_vec, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL reset_release edge %0d: got %b exp %b", i, dut_vec, e);
      end
      if (i == 6) begin
        checks++;
        if (ocupado !== 1'b0) begin
          errors++; $display("FAIL latency_early: ocupado=%b exp 0 at edge 6", ocupado);
        end
      end
      if (i == 7) begin
        checks++;
        if ({estado, ocupado, evento_entrada} !== 4'b0111) begin
          errors++; $display("FAIL latency_entry: got %b exp 0111", {estado, ocupado, evento_entrada});
        end
      end
      if (i == 8) begin
        checks++;
        if ({estado, evento_entrada} !== 3'b010) begin
          errors++; $display("FAIL entry_pulse_len: got %b exp 010", {estado, evento_entrada});
        end
      end
    end
  endtask

  task automatic test_vacate();
    int n_wait, n_ones;
    bit seen_wait, done;
    n_wait = 0; n_ones = 0; seen_wait = 0; done = 0;
    presenca = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL vacate cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      if (estado == 2'b10) begin
        seen_wait = 1; n_wait++;
        if (aviso) n_ones++;
      end else if (seen_wait && estado == 2'b00) done = 1;
    end
    checks++;
    if (!done || n_wait != H) begin
      errors++; $display("FAIL vacate_residency: got %0d cycles exp %0d (done=%0d)", n_wait, H, done);
    end
    checks++;
    if (n_ones != H / 2) begin
      errors++; $display("FAIL vacate_aviso_ones: got %0d exp %0d", n_ones, H / 2);
    end
  endtask

  task automatic test_glitch();
    bit bad;
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      presenca = (i < 3);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL glitch cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      if (dut_vec !== 5'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL glitch_ignored: outputs moved, last %b exp 00000", dut_vec);
    end
  endtask

  task automatic test_return();
    bit ok, evt_seen;
    ok = 0; evt_seen = 0;
    presenca = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL return_enter cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      ok = (estado == 2'b01);
    end
    presenca = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL return_leave cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      ok = (estado == 2'b10);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL return_timeout: estado=%b exp 10", estado);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL return_wait cycle %0d: got %b exp %b", i, dut_vec, e);
      end
    end
    presenca = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL return_back cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      if (evento_entrada) evt_seen = 1;
    end
    checks++;
    if (evt_seen || {estado, aviso} !== 3'b010) begin
      errors++; $display("FAIL return_no_event: got estado=%b aviso=%b evt_seen=%0d exp 01,0,0",
                         estado, aviso, evt_seen);
    end
  endtask

  task automatic test_force();
    bit held, reentered;
    held = 1; reentered = 0;
    forcar_livre = 1'b1;
    tick();
    forcar_livre = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (dut_vec !== e || estado !== 2'b00) begin
      errors++; $display("FAIL force_edge: got %b exp %b", dut_vec, e);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL force_hold cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      if (estado !== 2'b00) held = 0;
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL force_inhibit: estado=%b exp 00 while presence held", estado);
    end
    presenca = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL force_low cycle %0d: got %b exp %b", i, dut_vec, e);
      end
    end
    presenca = 1'b1;
    for (int i = 0; i < 20 && !reentered; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL force_reenter cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      reentered = (estado == 2'b01);
    end
    checks++;
    if (!reentered || evento_entrada !== 1'b1) begin
      errors++; $display("FAIL force_reentry_event: estado=%b evt=%b exp 01,1", estado, evento_entrada);
    end
  endtask

  task automatic test_random();
    int run_left;
    run_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        presenca = $urandom_range(0, 1);
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 45);
      end
      run_left--;
      forcar_livre = ($urandom_range(0, 99) < 2);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL random cycle %0d: got %b exp %b", i, dut_vec, e);
      end
    end
    forcar_livre = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 0;
    presenca = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (estado == 2'b01) presenca = 1'b0;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++; $display("FAIL midreset_setup cycle %0d: got %b exp %b", i, dut_vec, e);
      end
      ok = (estado == 2'b10) && (m_wait >= 3);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midreset_reach: estado=%b exp 10", estado);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 5'b0) begin
      errors++; $display("FAIL midreset_async: got %b exp 00000", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (dut_vec !== e || estado !== 2'b00) begin
      errors++; $display("FAIL midreset_after: got %b exp %b", dut_vec, e);
    end
  endtask

  // sequence + final report
  initial begin
    test_reset();
    test_vacate();
    test_glitch();
    test_return();
    test_force();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
